// File: rtl/lcd_hex_sequencer_pkg.sv
// Shared types and constants for the LCD hex sequencer.
// Holds the FSM encoding and the LCD/ASCII code points.
package lcd_hex_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADDR  = 2'd1,
        CHARS = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [7:0] LCD_CMD_SET_DDRAM = 8'h80;
    localparam logic [7:0] ASCII_ZERO        = 8'h30;
    localparam logic [7:0] ASCII_A           = 8'h41;

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        logic [7:0] w_n;
        w_n = {4'h0, n};
        if (n > 4'd9)
            return ASCII_A + (w_n - 8'd10);
        return ASCII_ZERO + w_n;
    endfunction

endpackage

// File: rtl/lcd_hex_sequencer_if.sv
// Request and byte-stream bundle between the sequencer,
// its requester and the low-level LCD write driver.
interface lcd_hex_sequencer_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 7
);

    logic                  start;
    logic [DATA_WIDTH-1:0] data_in;
    logic [ADDR_WIDTH-1:0] addr_in;
    logic                  out_valid;
    logic                  out_ready;
    logic [7:0]            out_byte;
    logic                  out_is_cmd;
    logic                  busy;
    logic                  done;

    // master: the sequencer, which sources the byte stream
    modport master (
        input  start,
        input  data_in,
        input  addr_in,
        input  out_ready,
        output out_valid,
        output out_byte,
        output out_is_cmd,
        output busy,
        output done
    );

    modport slave (
        output start,
        output data_in,
        output addr_in,
        output out_ready,
        input  out_valid,
        input  out_byte,
        input  out_is_cmd,
        input  busy,
        input  done
    );

endinterface

// File: rtl/lcd_hex_sequencer_binary2char.sv
// Binary2char: hex nibble to upper-case ASCII.
// Purely combinational; the caller registers the result.
module Binary2char
    import lcd_hex_sequencer_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [7:0] o_char
);

    always_comb begin
        o_char = hex_ascii(i_nibble);
    end

endmodule

// File: rtl/lcd_hex_sequencer.sv
// Emits a set-DDRAM-address command followed by the hex text
// of a latched value, most-significant nibble first.
module lcd_hex_sequencer
    import lcd_hex_sequencer_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 7
) (
    input  logic               clk,
    input  logic               reset_n,
    lcd_hex_sequencer_if.master bus
);

    localparam int NIBBLES = DATA_WIDTH / 4;
    localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    if ((DATA_WIDTH % 4) != 0 || DATA_WIDTH < 4 || DATA_WIDTH > 64)
    begin : g_bad_width
        $error("lcd_hex_sequencer: DATA_WIDTH must be 4..64, step 4");
    end

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_data;
    logic [IDX_W-1:0]      r_idx;
    logic                  r_valid;
    logic [7:0]            r_byte;
    logic                  r_is_cmd;
    logic                  r_busy;
    logic                  r_done;

    logic                  w_xfer;
    logic [IDX_W-1:0]      w_next_idx;
    logic [3:0]            w_nib;
    logic [7:0]            w_char;

    assign w_xfer = r_valid & bus.out_ready;

    // Look one nibble ahead so the next character is ready to
    // register on the same edge the current byte is accepted.
    always_comb begin
        w_next_idx = r_idx - IDX_W'(1);
        if (r_state == ADDR)
            w_next_idx = LAST_IDX;
        w_nib = 4'(r_data >> {w_next_idx, 2'b00});
    end

    Binary2char u_b2c (
        .i_nibble (w_nib),
        .o_char   (w_char)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= IDLE;
            r_data   <= '0;
            r_idx    <= '0;
            r_valid  <= 1'b0;
            r_byte   <= 8'h00;
            r_is_cmd <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_data   <= bus.data_in;
                        r_byte   <= LCD_CMD_SET_DDRAM | 8'(bus.addr_in);
                        r_is_cmd <= 1'b1;
                        r_valid  <= 1'b1;
                        r_busy   <= 1'b1;
                        r_state  <= ADDR;
                    end
                end
                ADDR: begin
                    if (w_xfer) begin
                        r_idx    <= LAST_IDX;
                        r_byte   <= w_char;
                        r_is_cmd <= 1'b0;
                        r_state  <= CHARS;
                    end
                end
                CHARS: begin
                    if (w_xfer) begin
                        if (r_idx == '0) begin
                            r_valid <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= DONE;
                        end else begin
                            r_idx  <= w_next_idx;
                            r_byte <= w_char;
                        end
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.out_valid  = r_valid;
    assign bus.out_byte   = r_byte;
    assign bus.out_is_cmd = r_is_cmd;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;

endmodule
